// File: rtl/router_pkg.sv
// Shared constants and types for the router input-port transmitter.
//   ADDR_W      - destination address width; one serial cycle per bit
//   PAD_CYCLES  - pad cycles between the address and the payload
//   BYTE_W      - payload byte width
//   state_e     - transmitter FSM states
//   addr_t      - destination address type
package router_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned PAD_CYCLES = 5;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned BIT_IDX_W  = $clog2(BYTE_W);

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PAD,
        DATA,
        STALL
    } state_e;

endpackage

// File: rtl/router_byte_shifter.sv
// One-byte hold register feeding an LSB-first byte shifter.
//   clk, reset    - clock, asynchronous active-high reset
//   accept_en_i   - upstream may hand over a byte (packet context allows it)
//   byte_valid_i  - byte offered; byte_ready_o - byte accepted when both high
//   byte_data_i   - byte value; byte_last_i - final byte of the packet
//   accept_o      - a byte handshake happens this cycle
//   hold_full_o   - hold register occupied
//   load_i        - move the pending byte (hold, or the byte accepted this
//                   cycle when hold is empty) into the shifter
//   shift_i       - advance the shifter by one bit
//   bit_next_o    - bit the shifter presents after this clock edge
//   last_o        - byte in the shifter is the last of its packet
//   bit_idx_o     - index of the bit currently presented
module router_byte_shifter (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               accept_en_i,
    input  logic                               byte_valid_i,
    output logic                               byte_ready_o,
    input  logic [router_pkg::BYTE_W-1:0]      byte_data_i,
    input  logic                               byte_last_i,
    output logic                               accept_o,
    output logic                               hold_full_o,
    input  logic                               load_i,
    input  logic                               shift_i,
    output logic                               bit_next_o,
    output logic                               last_o,
    output logic [router_pkg::BIT_IDX_W-1:0]   bit_idx_o
);
    import router_pkg::*;

    logic [BYTE_W-1:0]    hold_q;
    logic                 hold_last_q;
    logic                 hold_full_q;
    logic [BYTE_W-1:0]    shift_q;
    logic                 last_q;
    logic [BIT_IDX_W-1:0] idx_q;
    logic [BYTE_W-1:0]    src_byte;
    logic                 src_last;

    assign byte_ready_o = accept_en_i && !hold_full_q;
    assign accept_o     = byte_valid_i && byte_ready_o;
    assign hold_full_o  = hold_full_q;
    assign last_o       = last_q;
    assign bit_idx_o    = idx_q;

    // With an empty hold, a byte arriving on the load cycle bypasses the hold.
    always_comb begin
        src_byte   = hold_full_q ? hold_q : byte_data_i;
        src_last   = hold_full_q ? hold_last_q : byte_last_i;
        bit_next_o = shift_q[0];
        if (load_i) begin
            bit_next_o = src_byte[0];
        end else if (shift_i) begin
            bit_next_o = shift_q[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            last_q      <= 1'b0;
            idx_q       <= '0;
        end else if (load_i) begin
            shift_q     <= src_byte;
            last_q      <= src_last;
            idx_q       <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (shift_i) begin
                shift_q <= shift_q >> 1;
                idx_q   <= idx_q + 1'b1;
            end
            if (accept_o) begin
                hold_q      <= byte_data_i;
                hold_last_q <= byte_last_i;
                hold_full_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_port_driver.sv
// Serial transmitter for one router input port: address bits (LSB first),
// pad cycles, then payload bytes (LSB first) on din/frame_n/valid_n.
//   clk, reset            - clock, asynchronous active-high reset
//   hdr_valid/hdr_ready   - header handshake, hdr_addr = destination port
//   byte_valid/byte_ready - payload handshake, byte_data/byte_last
//   din, frame_n, valid_n - registered serial interface to the router
//   busy                  - packet in flight (header accept to packet end)
//   pkt_done              - one-cycle pulse after the final payload bit
module router_port_driver #(
    parameter int unsigned ADDR_W     = router_pkg::ADDR_W,
    parameter int unsigned PAD_CYCLES = router_pkg::PAD_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hdr_valid,
    output logic              hdr_ready,
    input  logic [ADDR_W-1:0] hdr_addr,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              din,
    output logic              frame_n,
    output logic              valid_n,
    output logic              busy,
    output logic              pkt_done
);
    import router_pkg::*;

    localparam int unsigned CNT_MAX = (ADDR_W > PAD_CYCLES) ? ADDR_W : PAD_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [BIT_IDX_W-1:0] LastIdx    = BIT_IDX_W'(BYTE_W - 1);
    localparam logic [BIT_IDX_W-1:0] PenultIdx  = BIT_IDX_W'(BYTE_W - 2);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, addr_sh;
    logic                last_acc_q, last_acc_d;
    logic                din_q, din_d;
    logic                frame_n_q, frame_n_d;
    logic                valid_n_q, valid_n_d;
    logic                busy_q, busy_d;
    logic                pkt_done_q, pkt_done_d;

    logic                accept_en;
    logic                byte_acc;
    logic                hold_full;
    logic                hold_avail;
    logic                load;
    logic                shift;
    logic                bit_next;
    logic                cur_last;
    logic                final_bit;
    logic [BIT_IDX_W-1:0] bit_idx;

    assign hdr_ready = !reset && (state_q == IDLE);
    assign accept_en = !reset && (state_q != IDLE) && !last_acc_q;
    // A byte accepted this cycle counts as available for an immediate load.
    assign hold_avail = hold_full || byte_acc;

    assign din      = din_q;
    assign frame_n  = frame_n_q;
    assign valid_n  = valid_n_q;
    assign busy     = busy_q;
    assign pkt_done = pkt_done_q;

    router_byte_shifter u_shifter (
        .clk          (clk),
        .reset        (reset),
        .accept_en_i  (accept_en),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .byte_data_i  (byte_data),
        .byte_last_i  (byte_last),
        .accept_o     (byte_acc),
        .hold_full_o  (hold_full),
        .load_i       (load),
        .shift_i      (shift),
        .bit_next_o   (bit_next),
        .last_o       (cur_last),
        .bit_idx_o    (bit_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        last_acc_d = last_acc_q;
        load       = 1'b0;
        shift      = 1'b0;
        final_bit  = 1'b0;
        pkt_done_d = 1'b0;
        if (byte_acc && byte_last) begin
            last_acc_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (hdr_valid && hdr_ready) begin
                    state_d    = ADDR;
                    cnt_d      = '0;
                    addr_d     = hdr_addr;
                    last_acc_d = 1'b0;
                end
            end
            ADDR: begin
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d = PAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PAD: begin
                if (cnt_q == CNT_W'(PAD_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (hold_avail) begin
                        state_d = DATA;
                        load    = 1'b1;
                    end else begin
                        state_d = STALL;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STALL: begin
                if (hold_avail) begin
                    state_d = DATA;
                    load    = 1'b1;
                end
            end
            DATA: begin
                if (bit_idx != LastIdx) begin
                    shift     = 1'b1;
                    final_bit = cur_last && (bit_idx == PenultIdx);
                end else if (cur_last) begin
                    state_d    = IDLE;
                    pkt_done_d = 1'b1;
                end else if (hold_avail) begin
                    load = 1'b1;
                end else begin
                    state_d = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial outputs are registered from next-state so they line up with state_q.
    always_comb begin
        addr_sh   = addr_d >> cnt_d;
        din_d     = 1'b0;
        frame_n_d = 1'b1;
        valid_n_d = 1'b1;
        unique case (state_d)
            IDLE: begin
                din_d = 1'b0;
            end
            ADDR: begin
                frame_n_d = 1'b0;
                din_d     = addr_sh[0];
            end
            PAD: begin
                frame_n_d = 1'b0;
                din_d     = 1'b1;
            end
            STALL: begin
                frame_n_d = 1'b0;
            end
            DATA: begin
                frame_n_d = final_bit;
                valid_n_d = 1'b0;
                din_d     = bit_next;
            end
            default: begin
                din_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            last_acc_q <= 1'b0;
            din_q      <= 1'b0;
            frame_n_q  <= 1'b1;
            valid_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            last_acc_q <= last_acc_d;
            din_q      <= din_d;
            frame_n_q  <= frame_n_d;
            valid_n_q  <= valid_n_d;
            busy_q     <= busy_d;
            pkt_done_q <= pkt_done_d;
        end
    end

endmodule

// File: tb/tb_router_port_driver.sv
// Directed bench for router_port_driver. Expected per-cycle serial output
// {din, frame_n, valid_n, pkt_done, busy, hdr_ready} is pushed to a queue when
// a packet is queued and popped on each cycle after the header handshake.
module tb_router_port_driver;
    import router_pkg::*;

    logic       clk;
    logic       reset;
    logic       hdr_valid;
    logic       hdr_ready;
    addr_t      hdr_addr;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic       busy;
    logic       pkt_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hdr_edge = 32'h4000_0000;
    int acc_cnt = 0;
    int byte_delay = 0;

    addr_t      hq[$];
    logic [8:0] bq[$];
    logic [5:0] exp_q[$];

    router_port_driver #(
        .ADDR_W     (ADDR_W),
        .PAD_CYCLES (PAD_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hdr_valid  (hdr_valid),
        .hdr_ready  (hdr_ready),
        .hdr_addr   (hdr_addr),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .din        (din),
        .frame_n    (frame_n),
        .valid_n    (valid_n),
        .busy       (busy),
        .pkt_done   (pkt_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec waveform of one packet starting the cycle after its header handshake.
    task automatic push_wave(input addr_t a, input logic [8:0] pb[$], input int stall,
                             input int trail);
        addr_t      ash;
        logic [7:0] bsh;
        for (int k = 0; k < int'(ADDR_W); k++) begin
            ash = a >> k;
            exp_q.push_back({ash[0], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        for (int k = 0; k < int'(PAD_CYCLES); k++) exp_q.push_back(6'b101010);
        for (int k = 0; k < stall; k++) exp_q.push_back(6'b001010);
        for (int b = 0; b < pb.size(); b++) begin
            for (int i = 0; i < 8; i++) begin
                bsh = pb[b][7:0] >> i;
                exp_q.push_back({bsh[0], (pb[b][8] && i == 7), 1'b0, 1'b0, 1'b1, 1'b0});
            end
        end
        exp_q.push_back(6'b011101);
        for (int k = 0; k < trail; k++) exp_q.push_back(6'b011001);
    endtask

    // Waits for the next header handshake, then compares one entry per cycle.
    task automatic run_expect(input string name, input int max_n);
        int         start;
        int         n;
        logic       got;
        logic [5:0] e;
        start = acc_cnt;
        got   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (acc_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
        check({name, " hdr accept"}, {7'd0, got}, 8'd1);
        if (got) begin
            n = 0;
            while (exp_q.size() > 0 && (max_n == 0 || n < max_n)) begin
                if (n > 0) @(negedge clk);
                e = exp_q.pop_front();
                n++;
                check($sformatf("%s T+%0d", name, n),
                      {2'b00, din, frame_n, valid_n, pkt_done, busy, hdr_ready}, {2'b00, e});
            end
        end
    endtask

    // Header and byte sources: present queue fronts, pop on handshake.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (hdr_valid && hdr_ready) begin
                hdr_edge = cyc;
                acc_cnt++;
                if (hq.size() > 0) void'(hq.pop_front());
            end
            if (byte_valid && byte_ready && bq.size() > 0) void'(bq.pop_front());
            #1;
            if (hq.size() > 0) begin
                hdr_valid = 1'b1;
                hdr_addr  = hq[0];
            end else begin
                hdr_valid = 1'b0;
            end
            if (bq.size() > 0 && (byte_delay == 0 || cyc - hdr_edge >= byte_delay - 1)) begin
                byte_valid = 1'b1;
                byte_last  = bq[0][8];
                byte_data  = bq[0][7:0];
            end else begin
                byte_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [8:0] pb[$];
        reset      = 1'b1;
        hdr_valid  = 1'b0;
        hdr_addr   = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        byte_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {3'd0, din, frame_n, valid_n, pkt_done, busy}, 8'b0000_1100);
        check("reset readies", {6'd0, hdr_ready, byte_ready}, 8'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle readies", {6'd0, hdr_ready, byte_ready}, 8'b10);

        // Header 5, single last byte A5 offered before the header.
        bq.push_back(9'h1A5);
        @(negedge clk);
        @(negedge clk);
        check("no byte accept in idle", {6'd0, byte_valid, byte_ready}, 8'b10);
        hq.push_back(4'h5);
        pb = {};
        pb.push_back(9'h1A5);
        push_wave(4'h5, pb, 0, 1);
        run_expect("pkt5_A5", 0);

        // Two bytes back-to-back, no gap between them.
        bq.push_back(9'h001);
        bq.push_back(9'h180);
        hq.push_back(4'hF);
        pb = {};
        pb.push_back(9'h001);
        pb.push_back(9'h180);
        push_wave(4'hF, pb, 0, 1);
        run_expect("pktF_01_80", 0);

        // Byte withheld until T+13: four stall cycles.
        hdr_edge   = 32'h4000_0000;
        byte_delay = 13;
        bq.push_back(9'h13C);
        hq.push_back(4'h3);
        pb = {};
        pb.push_back(9'h13C);
        push_wave(4'h3, pb, 4, 1);
        run_expect("pkt3_stall", 0);
        byte_delay = 0;

        // Second header held valid (with a new addr) while the first is sent.
        hq.push_back(4'h2);
        hq.push_back(4'h9);
        bq.push_back(9'h196);
        bq.push_back(9'h15A);
        pb = {};
        pb.push_back(9'h196);
        push_wave(4'h2, pb, 0, 0);
        pb = {};
        pb.push_back(9'h15A);
        push_wave(4'h9, pb, 0, 1);
        run_expect("two_pkts", 0);

        // Reset at T+12, in the middle of the payload.
        hq.push_back(4'h6);
        bq.push_back(9'h1C3);
        pb = {};
        pb.push_back(9'h1C3);
        push_wave(4'h6, pb, 0, 0);
        run_expect("pre_reset", 11);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async reset outputs", {3'd0, din, frame_n, valid_n, pkt_done, busy}, 8'b0000_1100);
        check("async reset readies", {6'd0, hdr_ready, byte_ready}, 8'd0);
        exp_q.delete();
        hq.delete();
        bq.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("in reset %0d", i),
                  {3'd0, din, frame_n, valid_n, pkt_done, busy}, 8'b0000_1100);
        end
        reset = 1'b0;
        #1;
        check("post reset readies", {6'd0, hdr_ready, byte_ready}, 8'b10);
        hq.push_back(4'hA);
        bq.push_back(9'h15A);
        pb = {};
        pb.push_back(9'h15A);
        push_wave(4'hA, pb, 0, 1);
        run_expect("post_reset_pkt", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
